// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        LEN,
        START,
        SEND,
        WAIT
    } sha256_state_e;

    localparam int         SHA256_BLOCK_WORDS = 16;
    localparam int         SHA256_LEN_IDX     = 14;
    localparam logic [7:0] SHA256_PAD_BYTE    = 8'h80;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
    } sha256_wr_t;

    // Keep the top k bytes of a big-endian word, append the 0x80 marker, zero the rest.
    // k == 4 means the word is full; its marker goes into the following word instead.
    function automatic logic [31:0] sha256_pad_word(input logic [31:0] w, input logic [2:0] k);
        logic [31:0] r;
        case (k)
            3'd0:    r = {SHA256_PAD_BYTE, 24'h0};
            3'd1:    r = {w[31:24], SHA256_PAD_BYTE, 16'h0};
            3'd2:    r = {w[31:16], SHA256_PAD_BYTE, 8'h0};
            3'd3:    r = {w[31:8], SHA256_PAD_BYTE};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Word-stream and core-side handshake between a message source, the padder and the SHA-256 core.
interface sha256_padder_if;
    logic        iMsgStart;
    logic [31:0] iWord;
    logic        iWordValid;
    logic        iLast;
    logic [2:0]  iLastBytes;
    logic        iCoreDone;
    logic        oReady;
    logic        oStart;
    logic [31:0] oData;
    logic        oValid;
    logic        oMsgDone;
    logic        oBusy;

    modport master (
        output iMsgStart, iWord, iWordValid, iLast, iLastBytes, iCoreDone,
        input  oReady, oStart, oData, oValid, oMsgDone, oBusy
    );

    modport slave (
        input  iMsgStart, iWord, iWordValid, iLast, iLastBytes, iCoreDone,
        output oReady, oStart, oData, oValid, oMsgDone, oBusy
    );
endinterface

// File: rtl/sha256_block_buffer.sv
// 16x32 block register file: one write port, one combinational indexed read, synchronous clear.
module sha256_block_buffer
    import sha256_pkg::*;
(
    input  logic        iClk,
    input  logic        clr,
    input  sha256_wr_t  wr,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata
);

    logic [SHA256_BLOCK_WORDS-1:0][31:0] mem;

    always_ff @(posedge iClk) begin
        if (clr)
            mem <= '0;
        else if (wr.we)
            mem[wr.addr] <= wr.data;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: buffers 32-bit words into 512-bit blocks, appends the 0x80
// marker, zero fill and 64-bit bit length, and streams each block to the core.
module sha256_padder
    import sha256_pkg::*;
(
    input  logic           iClk,
    input  logic           iReset_n,
    sha256_padder_if.slave bus
);

    localparam logic [4:0] IDX_FULL  = 5'(SHA256_BLOCK_WORDS);
    localparam logic [4:0] IDX_LEN   = 5'(SHA256_LEN_IDX);
    localparam logic [3:0] LAST_SEND = 4'(SHA256_BLOCK_WORDS - 1);

    sha256_state_e state, state_n;
    sha256_state_e ret_st, ret_n;
    logic [4:0]    idx, idx_n;
    logic [63:0]   len, len_n;
    logic [3:0]    cnt, cnt_n;
    logic          first_blk, first_n;
    logic          final_blk, final_n;
    logic          mark, mark_n;
    logic          ovf, ovf_n;
    logic          done, done_n;
    logic [2:0]    k;
    logic          clr;
    sha256_wr_t    wr;
    logic [31:0]   rdata;

    function automatic sha256_state_e send_entry(input logic first);
        return first ? START : SEND;
    endfunction

    assign k = (bus.iLastBytes > 3'd4) ? 3'd4 : bus.iLastBytes;

    sha256_block_buffer u_buf (
        .iClk  (iClk),
        .clr   (clr),
        .wr    (wr),
        .raddr (cnt),
        .rdata (rdata)
    );

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state     <= IDLE;
            ret_st    <= FILL;
            idx       <= '0;
            len       <= '0;
            cnt       <= '0;
            first_blk <= 1'b0;
            final_blk <= 1'b0;
            mark      <= 1'b0;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            ret_st    <= ret_n;
            idx       <= idx_n;
            len       <= len_n;
            cnt       <= cnt_n;
            first_blk <= first_n;
            final_blk <= final_n;
            mark      <= mark_n;
            ovf       <= ovf_n;
            done      <= done_n;
        end
    end

    // mark: a full final word left its 0x80 marker for the next slot.
    // ovf: the marker sits in word 14/15, so this block is zero-filled and a length-only block follows.
    always_comb begin
        state_n = state;
        ret_n   = ret_st;
        idx_n   = idx;
        len_n   = len;
        cnt_n   = '0;
        first_n = first_blk;
        final_n = final_blk;
        mark_n  = mark;
        ovf_n   = ovf;
        done_n  = 1'b0;
        wr      = '0;
        clr     = !iReset_n;

        case (state)
            IDLE: begin
                if (bus.iMsgStart) begin
                    state_n = FILL;
                    idx_n   = '0;
                    len_n   = '0;
                    first_n = 1'b1;
                    final_n = 1'b0;
                    mark_n  = 1'b0;
                    ovf_n   = 1'b0;
                    clr     = 1'b1;
                end
            end

            FILL: begin
                if (bus.iWordValid) begin
                    wr.we   = 1'b1;
                    wr.addr = idx[3:0];
                    idx_n   = idx + 5'd1;
                    if (bus.iLast) begin
                        wr.data = sha256_pad_word(bus.iWord, k);
                        len_n   = len + {58'd0, k, 3'b000};
                        mark_n  = (k == 3'd4);
                        ovf_n   = (k != 3'd4) && (idx >= IDX_LEN);
                        state_n = PAD;
                    end else begin
                        wr.data = bus.iWord;
                        len_n   = len + 64'd32;
                        if (idx_n == IDX_FULL) begin
                            state_n = send_entry(first_blk);
                            ret_n   = FILL;
                            final_n = 1'b0;
                        end
                    end
                end
            end

            PAD: begin
                if (idx == IDX_FULL) begin
                    state_n = send_entry(first_blk);
                    ret_n   = PAD;
                    final_n = 1'b0;
                    ovf_n   = 1'b0;
                end else if (mark || ovf || idx < IDX_LEN) begin
                    wr.we   = 1'b1;
                    wr.addr = idx[3:0];
                    wr.data = mark ? {SHA256_PAD_BYTE, 24'h0} : 32'h0;
                    mark_n  = 1'b0;
                    if (mark)
                        ovf_n = (idx >= IDX_LEN);
                    idx_n   = idx + 5'd1;
                    // Jump straight to LEN on the last zero word to keep per-block latency at 16.
                    if (idx_n == IDX_LEN && !ovf_n)
                        state_n = LEN;
                end else begin
                    state_n = LEN;
                end
            end

            LEN: begin
                wr.we   = 1'b1;
                wr.addr = idx[3:0];
                idx_n   = idx + 5'd1;
                if (idx == IDX_LEN) begin
                    wr.data = len[63:32];
                end else begin
                    wr.data = len[31:0];
                    state_n = send_entry(first_blk);
                    final_n = 1'b1;
                end
            end

            START: begin
                state_n = SEND;
                first_n = 1'b0;
            end

            SEND: begin
                cnt_n = cnt + 4'd1;
                if (cnt == LAST_SEND)
                    state_n = WAIT;
            end

            WAIT: begin
                if (bus.iCoreDone) begin
                    idx_n = '0;
                    if (final_blk) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ret_st;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign bus.oReady   = (state == FILL);
    assign bus.oStart   = (state == START);
    assign bus.oValid   = (state == SEND);
    assign bus.oData    = (state == SEND) ? rdata : 32'h0;
    assign bus.oMsgDone = done;
    assign bus.oBusy    = (state != IDLE);

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: directed messages, expected core-side events queued
// up front and popped by an independent output monitor; a small core model returns iCoreDone.
module tb_sha256_padder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha256_padder_if bus();

    sha256_padder dut (
        .iClk     (clk),
        .iReset_n (rst_n),
        .bus      (bus)
    );

    localparam int K_START = 0;
    localparam int K_DATA  = 1;
    localparam int K_DONE  = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] msg[$];
    int          ntot = 0;
    int          nbad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        ntot++;
        if (act !== req) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic exp_ev(input int kind, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_z(input int n);
        for (int i = 0; i < n; i++) exp_ev(K_DATA, 32'h0);
    endtask

    task automatic fill_msg(input int n, input logic [31:0] base);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(base + 32'(i));
    endtask

    task automatic check_ev(input string name, input int kind, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            ntot++;
            nbad++;
            $display("FAIL %s: got unexpected output %0h, want nothing", name, d);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, 64'(kind), 64'(e.kind));
            if (kind == K_DATA) chk(name, {32'h0, d}, {32'h0, e.data});
        end
    endtask

    // Output monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bus.oStart === 1'b1) check_ev("start", K_START, 32'h0);
            if (bus.oValid === 1'b1) begin
                check_ev("data", K_DATA, bus.oData);
                chk("ready_in_send", {63'h0, bus.oReady}, 64'h0);
            end else begin
                chk("data_idle", {32'h0, bus.oData}, 64'h0);
            end
            if (bus.oMsgDone === 1'b1) check_ev("done", K_DONE, 32'h0);
        end
    end

    // Core model: acknowledges every 16-word block a few cycles after its last word.
    initial begin
        int ccnt;
        int cdly;
        ccnt = 0;
        cdly = 0;
        bus.iCoreDone = 1'b0;
        forever begin
            @(negedge clk);
            bus.iCoreDone = 1'b0;
            if (!rst_n) begin
                ccnt = 0;
                cdly = 0;
            end else begin
                if (cdly > 0) begin
                    cdly--;
                    if (cdly == 0) bus.iCoreDone = 1'b1;
                end
                if (bus.oValid === 1'b1) begin
                    ccnt++;
                    if (ccnt == 16) begin
                        ccnt = 0;
                        cdly = 3;
                    end
                end
            end
        end
    end

    task automatic start_msg();
        bus.iMsgStart = 1'b1;
        @(negedge clk);
        bus.iMsgStart = 1'b0;
    endtask

    task automatic put_words(input logic [2:0] lb, input bit lat_chk);
        int t;
        int lat;
        for (int i = 0; i < msg.size(); i++) begin
            bus.iWord      = msg[i];
            bus.iLast      = (i == msg.size() - 1);
            bus.iLastBytes = (i == msg.size() - 1) ? lb : 3'd0;
            bus.iWordValid = 1'b1;
            t = 0;
            while (bus.oReady !== 1'b1 && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (bus.oReady !== 1'b1) begin
                ntot++;
                nbad++;
                $display("FAIL xfer_timeout: word %0d not accepted, want accepted", i);
            end
            @(negedge clk);
        end
        bus.iWordValid = 1'b0;
        bus.iLast      = 1'b0;
        if (lat_chk) begin
            lat = 0;
            while (bus.oValid !== 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk("latency_le16", {63'h0, (lat <= 16)}, 64'h1);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (bus.oMsgDone !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("msg_done_seen", {63'h0, bus.oMsgDone}, 64'h1);
        @(negedge clk);
        chk("idle_after_done", {63'h0, bus.oBusy}, 64'h0);
    endtask

    task automatic run_msg(input logic [2:0] lb, input bit pre, input bit lat);
        if (pre) begin
            bus.iWord      = msg[0];
            bus.iLast      = 1'b0;
            bus.iWordValid = 1'b1;
            repeat (3) @(negedge clk);
            chk("ready_idle", {63'h0, bus.oReady}, 64'h0);
        end
        start_msg();
        chk("busy_fill", {63'h0, bus.oBusy}, 64'h1);
        put_words(lb, lat);
        wait_done();
    endtask

    task automatic exp_abc();
        exp_ev(K_START, 32'h0);
        exp_ev(K_DATA, 32'h61626380);
        exp_z(14);
        exp_ev(K_DATA, 32'h00000018);
        exp_ev(K_DONE, 32'h0);
    endtask

    initial begin
        int n;
        int t;
        bus.iMsgStart  = 1'b0;
        bus.iWord      = 32'h0;
        bus.iWordValid = 1'b0;
        bus.iLast      = 1'b0;
        bus.iLastBytes = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready",   {63'h0, bus.oReady},   64'h0);
        chk("rst_start",   {63'h0, bus.oStart},   64'h0);
        chk("rst_valid",   {63'h0, bus.oValid},   64'h0);
        chk("rst_msgdone", {63'h0, bus.oMsgDone}, 64'h0);
        chk("rst_busy",    {63'h0, bus.oBusy},    64'h0);
        chk("rst_data",    {32'h0, bus.oData},    64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc"
        msg.delete();
        msg.push_back(32'h61626300);
        exp_abc();
        run_msg(3'd3, 1'b0, 1'b1);

        // empty message; payload bytes must be discarded
        msg.delete();
        msg.push_back(32'hDEADBEEF);
        exp_ev(K_START, 32'h0);
        exp_ev(K_DATA, 32'h80000000);
        exp_z(14);
        exp_ev(K_DATA, 32'h00000000);
        exp_ev(K_DONE, 32'h0);
        run_msg(3'd0, 1'b0, 1'b1);

        // 14 full words: marker lands in word 14, length needs a second block
        fill_msg(14, 32'hA5A50000);
        exp_ev(K_START, 32'h0);
        for (int i = 0; i < 14; i++) exp_ev(K_DATA, msg[i]);
        exp_ev(K_DATA, 32'h80000000);
        exp_ev(K_DATA, 32'h0);
        exp_z(15);
        exp_ev(K_DATA, 32'h000001C0);
        exp_ev(K_DONE, 32'h0);
        run_msg(3'd4, 1'b0, 1'b0);

        // 16 full words: marker opens block 2
        fill_msg(16, 32'h5A5A0100);
        exp_ev(K_START, 32'h0);
        for (int i = 0; i < 16; i++) exp_ev(K_DATA, msg[i]);
        exp_ev(K_DATA, 32'h80000000);
        exp_z(14);
        exp_ev(K_DATA, 32'h00000200);
        exp_ev(K_DONE, 32'h0);
        run_msg(3'd4, 1'b0, 1'b0);

        // backpressure: valid held high in IDLE and through block-1 SEND/WAIT
        fill_msg(16, 32'h3C3C0200);
        msg.push_back(32'h11223344);
        exp_ev(K_START, 32'h0);
        for (int i = 0; i < 16; i++) exp_ev(K_DATA, msg[i]);
        exp_ev(K_DATA, 32'h11228000);
        exp_z(14);
        exp_ev(K_DATA, 32'h00000210);
        exp_ev(K_DONE, 32'h0);
        run_msg(3'd2, 1'b1, 1'b0);

        // iLastBytes=7 behaves as a full word
        msg.delete();
        msg.push_back(32'hCAFEF00D);
        exp_ev(K_START, 32'h0);
        exp_ev(K_DATA, 32'hCAFEF00D);
        exp_ev(K_DATA, 32'h80000000);
        exp_z(13);
        exp_ev(K_DATA, 32'h00000020);
        exp_ev(K_DONE, 32'h0);
        run_msg(3'd7, 1'b0, 1'b0);

        // marker inside word 15
        fill_msg(15, 32'h0F0F0300);
        msg.push_back(32'h77665544);
        exp_ev(K_START, 32'h0);
        for (int i = 0; i < 15; i++) exp_ev(K_DATA, msg[i]);
        exp_ev(K_DATA, 32'h77800000);
        exp_z(15);
        exp_ev(K_DATA, 32'h000001E8);
        exp_ev(K_DONE, 32'h0);
        run_msg(3'd1, 1'b0, 1'b0);

        // reset during the 5th SEND cycle
        msg.delete();
        msg.push_back(32'h61626300);
        exp_ev(K_START, 32'h0);
        exp_ev(K_DATA, 32'h61626380);
        exp_z(4);
        start_msg();
        put_words(3'd3, 1'b0);
        n = 0;
        t = 0;
        while (n < 5 && t < 100) begin
            if (bus.oValid === 1'b1) n++;
            if (n < 5) begin
                @(negedge clk);
                t++;
            end
        end
        chk("sends_before_abort", 64'(n), 64'd5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready",   {63'h0, bus.oReady},   64'h0);
        chk("abort_start",   {63'h0, bus.oStart},   64'h0);
        chk("abort_valid",   {63'h0, bus.oValid},   64'h0);
        chk("abort_msgdone", {63'h0, bus.oMsgDone}, 64'h0);
        chk("abort_busy",    {63'h0, bus.oBusy},    64'h0);
        chk("abort_data",    {32'h0, bus.oData},    64'h0);
        chk("queue_after_abort", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        exp_abc();
        run_msg(3'd3, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, named as follows.
REQ-002 iClk  in  1  Rising-edge clock.
REQ-003 iReset_n  in  1  Synchronous reset, active-low.
REQ-004 iMsgStart  in  1  One-cycle pulse that opens a new message; clears the length counter and the word index.
REQ-005 iWord  in  32  Message word, big-endian; iWord[31:24] is the first byte.
REQ-006 iWordValid  in  1  iWord qualifier; a word transfers when iWordValid && oReady.
REQ-007 iLast  in  1  Marks the transferring word as the final word of the message.
REQ-008 iLastBytes  in  3  Number of valid bytes in the final word, 0..4; values 5..7 are treated as 4; ignored when iLast=0.
REQ-009 iCoreDone  in  1  Pulse from the SHA-256 core indicating it has finished compressing a block.
REQ-010 oReady  out  1  Block can accept a word.
REQ-011 oStart  out  1  One-cycle pulse to core START, issued before the first word of a message's first block.
REQ-012 oData  out  32  Padded word to core DATA_IN.
REQ-013 oValid  out  1  Padded word qualifier to core DATA_VALID.
REQ-014 oMsgDone  out  1  One-cycle pulse when the core completes the final block of the message.
REQ-015 oBusy  out  1  High in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, FILL, PAD, LEN, START, SEND and WAIT.
REQ-017 IDLE SHALL go to FILL on iMsgStart; iWordValid in IDLE SHALL be ignored.
REQ-018 oReady SHALL be 1 only in FILL.
REQ-019 In FILL, each transfer SHALL write buffer[idx], advance idx and add 32 to the 64-bit bit-length counter; a full word with iLast=1 SHALL add 8*iLastBytes instead.
REQ-020 The final word SHALL keep its top k=iLastBytes bytes, place 0x80 in byte k and zero the remaining bytes.
REQ-021 When k=4, the 0x80000000 word SHALL be written to the next index, which PAD handles.
REQ-022 When idx reaches 16 before the last word, the block SHALL be sent (START/SEND/WAIT) and FILL SHALL then resume at idx=0.
REQ-023 PAD SHALL zero-fill the buffer up to word 13.
REQ-024 If the 0x80 byte lands at idx 14 or 15, PAD SHALL zero-fill to word 15, send that block, and then build a second block of zeros for words 0..13.
REQ-025 LEN SHALL write word14=len[63:32] and word15=len[31:0] and then proceed to send.
REQ-026 START SHALL assert oStart for exactly one cycle, only for the first block of a message; later blocks SHALL go directly to SEND.
REQ-027 SEND SHALL drive words 0..15 on 16 consecutive cycles with oValid=1; oValid SHALL otherwise be 0 and oData SHALL be 0 when oValid=0.
REQ-028 WAIT SHALL hold until iCoreDone.
REQ-029 On iCoreDone after the final block, WAIT SHALL pulse oMsgDone in the next cycle and return to IDLE; otherwise WAIT SHALL return to FILL or PAD.
REQ-030 iMsgStart outside IDLE SHALL be ignored.
REQ-031 iCoreDone outside WAIT SHALL be ignored.
REQ-032 The length counter SHALL wrap modulo 2^64.
REQ-033 Latency from the final-word transfer to the first oValid SHALL be at most 16 cycles per block.

Reset
REQ-034 While iReset_n=0 at a clock edge, the block SHALL set state=IDLE, idx=0, length=0 and the buffer to zero.
REQ-035 While iReset_n=0 at a clock edge, the block SHALL drive oReady, oStart, oValid, oMsgDone and oBusy to 0 and oData to 0.
REQ-036 Reset in any state, including mid-SEND, SHALL abort the message with no further oValid.

Structure
REQ-037 Package sha256_pkg SHALL hold the state enum, SHA256_BLOCK_WORDS=16, SHA256_LEN_IDX=14 and SHA256_PAD_BYTE=8'h80.
REQ-038 There SHALL be one sub-module, sha256_block_buffer: a 16x32 register file with a write port, an indexed read port and a zero-clear.

Verification
REQ-039 Bench scenario "abc": iWord=0x61626300 with iLast=1 and iLastBytes=3 -> oStart, then 0x61626380, 14 words of 0, then 0x00000018, then oMsgDone after iCoreDone.
REQ-040 Bench scenario empty message: iLast=1 with iLastBytes=0 -> 0x80000000, 14 words of 0, then 0x00000000.
REQ-041 Bench scenario 14 full words, last word with k=4 -> block 1 = data, 0x80000000, 0; block 2 = 15 words of 0, then 0x000001C0; oStart only before block 1.
REQ-042 Bench scenario 16 full words -> block 1 = data; block 2 = 0x80000000, 14 words of 0, then 0x00000200.
REQ-043 Bench scenario backpressure: iWordValid held high during SEND/WAIT -> oReady=0 and no word lost or duplicated.
REQ-044 Bench scenario reset asserted on the 5th SEND cycle -> all outputs 0 on the next edge, and a following "abc" run is correct.
